// File: rtl/model_vector_integration_feeder_if.sv
// Handshake/data bundle between a sample producer/consumer and the vector integration feeder.
// PERIOD_IN is present only when MODEL_VECTOR_INTEGRATION_FEEDER_PERIOD_EN is defined.
interface model_vector_integration_feeder_if #(
    parameter int DATA_SIZE = 64
);
    logic                 START;
    logic                 READY;
    logic                 DATA_IN_ENABLE;
    logic                 FIFO_FULL;
    logic                 FIFO_EMPTY;
    logic                 OVERFLOW;
    logic                 DATA_OUT_READY;
    logic                 DATA_OUT_VECTOR_ENABLE;
    logic                 DATA_OUT_SCALAR_ENABLE;
    logic [DATA_SIZE-1:0] SIZE_IN;
    logic [DATA_SIZE-1:0] LENGTH_IN;
`ifdef MODEL_VECTOR_INTEGRATION_FEEDER_PERIOD_EN
    logic [DATA_SIZE-1:0] PERIOD_IN;
`endif
    logic [DATA_SIZE-1:0] DATA_IN;
    logic [DATA_SIZE-1:0] DATA_OUT;

    modport master (
        output START, DATA_IN_ENABLE, DATA_OUT_READY, SIZE_IN, LENGTH_IN, DATA_IN,
`ifdef MODEL_VECTOR_INTEGRATION_FEEDER_PERIOD_EN
        output PERIOD_IN,
`endif
        input  READY, FIFO_FULL, FIFO_EMPTY, OVERFLOW,
        input  DATA_OUT_VECTOR_ENABLE, DATA_OUT_SCALAR_ENABLE, DATA_OUT
    );

    modport slave (
        input  START, DATA_IN_ENABLE, DATA_OUT_READY, SIZE_IN, LENGTH_IN, DATA_IN,
`ifdef MODEL_VECTOR_INTEGRATION_FEEDER_PERIOD_EN
        input  PERIOD_IN,
`endif
        output READY, FIFO_FULL, FIFO_EMPTY, OVERFLOW,
        output DATA_OUT_VECTOR_ENABLE, DATA_OUT_SCALAR_ENABLE, DATA_OUT
    );
endinterface

// File: rtl/model_vector_integration_feeder.sv
// Sample FIFO replayed as a SIZE x LENGTH stream for the vector integrator.
// Optional minimum sample spacing: define MODEL_VECTOR_INTEGRATION_FEEDER_PERIOD_EN.
module model_vector_integration_feeder #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_SIZE    = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    model_vector_integration_feeder_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, FEED = 2'd1, DONE = 2'd2} state_t;

    localparam logic [CONTROL_SIZE-1:0] ONE_C   = CONTROL_SIZE'(1);
    localparam logic [CONTROL_SIZE-1:0] ZERO_C  = {CONTROL_SIZE{1'b0}};
    localparam logic [ADDR_SIZE:0]      DEPTH_C = (ADDR_SIZE + 1)'(FIFO_DEPTH);

    state_t                  state_q, state_d;
    logic [DATA_SIZE-1:0]    mem_q [FIFO_DEPTH];
    logic [ADDR_SIZE-1:0]    wr_ptr_q, rd_ptr_q;
    logic [ADDR_SIZE:0]      count_q, count_d;
    logic [CONTROL_SIZE-1:0] size_q, size_d, length_q, length_d;
    logic [CONTROL_SIZE-1:0] i_q, i_d, j_q, j_d;
    logic                    zero_xfer_q, zero_xfer_d;
    logic                    ready_d;
    logic [DATA_SIZE-1:0]    data_out_q;
    logic                    scalar_q, vector_q, ready_q, full_q, empty_q, overflow_q;
    logic                    push_s, pop_s, pace_ok_s, zero_s;

    assign zero_s = (CONTROL_SIZE'(bus.SIZE_IN) == ZERO_C) || (CONTROL_SIZE'(bus.LENGTH_IN) == ZERO_C);
    assign pop_s  = (state_q == FEED) && (count_q != '0) && bus.DATA_OUT_READY && pace_ok_s;
    // A full FIFO still takes a push when the same edge frees a slot.
    assign push_s = bus.DATA_IN_ENABLE && ((count_q != DEPTH_C) || pop_s);

`ifdef MODEL_VECTOR_INTEGRATION_FEEDER_PERIOD_EN
    logic [CONTROL_SIZE-1:0] period_q, period_d, pace_q, pace_d;

    assign pace_ok_s = (pace_q == ZERO_C);

    // Pacing down-counter: reloads PERIOD-1 on each pop, cleared outside FEED.
    always_comb begin
        period_d = period_q;
        pace_d   = pace_q;
        if ((state_q == IDLE) && bus.START) begin
            period_d = CONTROL_SIZE'(bus.PERIOD_IN);
        end else begin
            period_d = period_q;
        end
        if (state_d != FEED) begin
            pace_d = ZERO_C;
        end else if (pop_s) begin
            pace_d = (period_q > ONE_C) ? (period_q - ONE_C) : ZERO_C;
        end else if (pace_q != ZERO_C) begin
            pace_d = pace_q - ONE_C;
        end else begin
            pace_d = pace_q;
        end
    end

    // Pacing registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            period_q <= ZERO_C;
            pace_q   <= ZERO_C;
        end else begin
            period_q <= period_d;
            pace_q   <= pace_d;
        end
    end
`else
    assign pace_ok_s = 1'b1;
`endif

    // FIFO occupancy next state.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (ADDR_SIZE + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_SIZE + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FSM next state and element/sample counters.
    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        length_d    = length_q;
        i_d         = i_q;
        j_d         = j_q;
        zero_xfer_d = zero_xfer_q;
        ready_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    size_d      = CONTROL_SIZE'(bus.SIZE_IN);
                    length_d    = CONTROL_SIZE'(bus.LENGTH_IN);
                    i_d         = ZERO_C;
                    j_d         = ZERO_C;
                    zero_xfer_d = zero_s;
                    ready_d     = zero_s;
                    state_d     = zero_s ? DONE : FEED;
                end else begin
                    state_d = IDLE;
                end
            end
            FEED: begin
                if (pop_s && (j_q == length_q - ONE_C)) begin
                    j_d = ZERO_C;
                    i_d = i_q + ONE_C;
                    state_d = (i_q == size_q - ONE_C) ? DONE : FEED;
                end else if (pop_s) begin
                    j_d = j_q + ONE_C;
                end else begin
                    j_d = j_q;
                end
            end
            DONE: begin
                // Zero-size transfers already pulsed READY on entry.
                ready_d = !zero_xfer_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sample storage; contents are don't-care until written.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= bus.DATA_IN;
        end
    end

    // Control state, FIFO pointers and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            size_q      <= ZERO_C;
            length_q    <= ZERO_C;
            i_q         <= ZERO_C;
            j_q         <= ZERO_C;
            zero_xfer_q <= 1'b0;
            data_out_q  <= '0;
            scalar_q    <= 1'b0;
            vector_q    <= 1'b0;
            ready_q     <= 1'b0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= push_s ? wr_ptr_q + ADDR_SIZE'(1) : wr_ptr_q;
            rd_ptr_q    <= pop_s ? rd_ptr_q + ADDR_SIZE'(1) : rd_ptr_q;
            count_q     <= count_d;
            size_q      <= size_d;
            length_q    <= length_d;
            i_q         <= i_d;
            j_q         <= j_d;
            zero_xfer_q <= zero_xfer_d;
            data_out_q  <= pop_s ? mem_q[rd_ptr_q] : data_out_q;
            scalar_q    <= pop_s;
            vector_q    <= pop_s && (j_q == ZERO_C);
            ready_q     <= ready_d;
            full_q      <= (count_d == DEPTH_C);
            empty_q     <= (count_d == '0);
            overflow_q  <= overflow_q || (bus.DATA_IN_ENABLE && !push_s);
        end
    end

    assign bus.DATA_OUT               = data_out_q;
    assign bus.DATA_OUT_SCALAR_ENABLE = scalar_q;
    assign bus.DATA_OUT_VECTOR_ENABLE = vector_q;
    assign bus.READY                  = ready_q;
    assign bus.FIFO_FULL              = full_q;
    assign bus.FIFO_EMPTY             = empty_q;
    assign bus.OVERFLOW               = overflow_q;
endmodule

// File: doc/model_vector_integration_feeder.md
Name: model_vector_integration_feeder

Overview:
Upstream stage of the vector integration unit: buffers raw samples in a FIFO and replays them as a SIZE_IN x LENGTH_IN sample stream on the integrator's input protocol. DATA_OUT_VECTOR_ENABLE and DATA_OUT_SCALAR_ENABLE connect directly to the integrator's DATA_IN_VECTOR_ENABLE and DATA_IN_SCALAR_ENABLE. It decouples sample producers from integrator timing and applies backpressure.

Parameters:
DATA_SIZE, 64, sample/data width in bits
CONTROL_SIZE, 64, width of internal element/sample counters
FIFO_DEPTH, 16, sample buffer entries (power of two, >=2)
ADDR_SIZE, 4, log2(FIFO_DEPTH)

Ports:
CLK  in  1  clock; all logic on rising edge
RST  in  1  synchronous, active-high reset
START  in  1  begin one transfer; sampled only in IDLE
READY  out  1  one-cycle pulse when a transfer completes
DATA_IN_ENABLE  in  1  push strobe for DATA_IN
FIFO_FULL  out  1  FIFO holds FIFO_DEPTH entries
FIFO_EMPTY  out  1  FIFO holds 0 entries
OVERFLOW  out  1  sticky; push attempted while full without a same-cycle pop
DATA_OUT_READY  in  1  consumer can accept a sample this cycle
DATA_OUT_VECTOR_ENABLE  out  1  pulse on first sample of each vector element
DATA_OUT_SCALAR_ENABLE  out  1  pulse on every emitted sample
SIZE_IN  in  DATA_SIZE  number of vector elements; latched at START
LENGTH_IN  in  DATA_SIZE  samples per element; latched at START
PERIOD_IN  in  DATA_SIZE  minimum sample spacing; present only with the macro
DATA_IN  in  DATA_SIZE  sample to push
DATA_OUT  out  DATA_SIZE  emitted sample; registered

Behaviour:
- Reset: all outputs 0 except FIFO_EMPTY=1. FIFO pointers and count, counters i/j and the OVERFLOW flag are cleared. FSM goes to IDLE.
- Reset mid-transfer: discards the transfer and flushes the FIFO; no READY pulse is issued.
- Reset dominance: RST wins over every simultaneous event.
- FIFO push:
  - Pushes are accepted in any state.
  - A push when count<FIFO_DEPTH writes DATA_IN.
  - A push when full is accepted only if a pop happens in the same cycle. Otherwise it is dropped and OVERFLOW is set (cleared only by RST).
  - Simultaneous push and pop leaves the count unchanged.
  - No fall-through: a pushed entry can be popped no earlier than the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - FIFO_FULL and FIFO_EMPTY are registered and reflect the count after the current edge.
- FSM states: IDLE, FEED, DONE.
  - IDLE:
    - START=1 latches SIZE_IN and LENGTH_IN and sets i=0, j=0.
    - If SIZE_IN==0 or LENGTH_IN==0, go to DONE; otherwise go to FEED.
    - START in FEED or DONE is ignored.
  - FEED:
    - Pop condition: FIFO not empty AND DATA_OUT_READY=1 (AND pacing satisfied when the macro is defined).
    - On a pop, next cycle: DATA_OUT = popped word, DATA_OUT_SCALAR_ENABLE=1, DATA_OUT_VECTOR_ENABLE = (j==0).
    - Latency: 1 cycle from the pop-condition cycle to the strobe.
    - Counters: j increments on each pop. At j==LENGTH-1, j wraps to 0 and i increments.
    - The pop with i==SIZE-1 and j==LENGTH-1 moves the FSM to DONE.
    - Without a pop, both strobes are 0 and DATA_OUT holds its last value.
  - DONE: READY=1 for exactly one cycle, then IDLE. READY is asserted one cycle after the final strobe, or one cycle after START for a zero-size transfer.
- Data leftover: entries beyond SIZE*LENGTH stay in the FIFO for the next transfer.
- Width rules:
  - i and j are CONTROL_SIZE wide.
  - SIZE and LENGTH are compared after truncation to CONTROL_SIZE.
  - The product SIZE*LENGTH is never formed.

Optional Feature:
Macro MODEL_VECTOR_INTEGRATION_FEEDER_PERIOD_EN.
- Defined:
  - PERIOD_IN exists and is latched at START.
  - A down-counter loads PERIOD-1 on each pop.
  - A further pop requires the counter to be 0, so strobes are at least PERIOD cycles apart.
  - PERIOD 0 or 1 means back-to-back.
  - The counter clears on RST and when the FSM leaves FEED.
- Undefined: no PERIOD_IN port and no counter; pops may occur on consecutive cycles.

Test Plan:
1. Basic order and framing. Push 6 words 0x10..0x15, then START with SIZE=2, LENGTH=3 and DATA_OUT_READY=1.
   -> DATA_OUT is 0x10..0x15 on six consecutive cycles.
   -> DATA_OUT_SCALAR_ENABLE=1 on all six; DATA_OUT_VECTOR_ENABLE=1 only with 0x10 and 0x13.
   -> READY pulses once, the cycle after the 0x15 strobe; FIFO_EMPTY=1.
2. Backpressure. Same setup as scenario 1, with DATA_OUT_READY held 0 for cycles 2-4 of FEED.
   -> No strobes while DATA_OUT_READY is 0; DATA_OUT holds.
   -> Sequence resumes intact; READY still pulses exactly once.
3. Full FIFO and overflow. With FIFO_DEPTH=16 and no pops, push 17 words.
   -> FIFO_FULL=1 after the 16th push; 17th push dropped; OVERFLOW=1.
   -> Then push while popping in FEED: entry accepted, OVERFLOW unchanged, count stays 16.
4. Zero size and START filtering. START with SIZE=0, LENGTH=5.
   -> READY=1 on the next cycle and no strobes.
   -> A START pulse during FEED of a SIZE=1, LENGTH=4 transfer has no effect; exactly 4 strobes are emitted.
5. Reset mid-transfer. Assert RST after 2 of 6 samples.
   -> Next cycle: all strobes 0, READY 0, FIFO_EMPTY=1, OVERFLOW=0, FSM in IDLE.
   -> A new transfer of SIZE=1, LENGTH=2 emits its samples starting at the first word pushed after reset, with VECTOR_ENABLE on that first word.
6. Pacing (macro defined). Push 4 words, then START with PERIOD=3, SIZE=1, LENGTH=4.
   -> Strobes appear exactly 3 cycles apart.
   -> With PERIOD=1, strobes are back-to-back.
